// File: rtl/snake_score_display_pkg.sv
// Shared definitions for the two-snake LED game: game states, display digit codes
// and the active-low seven-segment encoder.
package snake_score_display_pkg;

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_START      = 2'd1,
        ST_FINISH     = 2'd2,
        ST_FINISH_ALT = 2'd3
    } game_state_e;

    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_DASH  = 4'd11;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba pattern for a digit code (0..9, BLANK, DASH).
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd11:   seg = 7'b0111111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/snake_score_display_bcd_sat_counter.sv
// Two-digit BCD counter with synchronous clear and saturation at 99.
module bcd_sat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_r;
    logic [7:0] count_nxt_s;

    assign count = count_r;

    // Next BCD value: carry ones into tens, hold at 99.
    always_comb begin
        count_nxt_s = count_r;
        if (inc) begin
            if (count_r == 8'h99) begin
                count_nxt_s = count_r;
            end else if (count_r[3:0] == 4'd9) begin
                count_nxt_s = {count_r[7:4] + 4'd1, 4'd0};
            end else begin
                count_nxt_s = {count_r[7:4], count_r[3:0] + 4'd1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with async reset and synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 8'h00;
        end else if (clr) begin
            count_r <= 8'h00;
        end else begin
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/snake_score_display.sv
// Score stage of the two-snake game: filters snake positions, counts contacts and
// elapsed seconds, and scans the result onto a 4-digit seven-segment display.
module snake_score_display
    import snake_score_display_pkg::*;
#(
    parameter int TICK_CYCLES  = 100_000_000,
    parameter int SCAN_CYCLES  = 32_768,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [15:0] pos_a,
    input  logic [15:0] pos_b,
    output logic [3:0]  digit,
    output logic [6:0]  display,
    output logic        contact_evt
);

    localparam int TICK_W  = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
    localparam int SCAN_W  = (SCAN_CYCLES  > 1) ? $clog2(SCAN_CYCLES)  : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [15:0] a_sync1_r, a_sync2_r, a_prev_r, a_filt_r;
    logic [15:0] b_sync1_r, b_sync2_r, b_prev_r, b_filt_r;
    logic        contact_s, contact_q_r, con_inc_s;
    logic        is_reset_s, is_start_s, is_finish_s;
    logic [TICK_W-1:0]  tick_r;
    logic               tick_s;
    logic [BLINK_W-1:0] blink_r;
    logic               hide_r;
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         scan_idx_r, idx_nxt_s, show_idx_s;
    logic               scan_on_r, scan_wrap_s, on_nxt_s;
    logic [3:0]         code_s;
    logic [7:0]         sec_bcd_s, con_bcd_s;

    assign is_reset_s  = (state == ST_RESET);
    assign is_start_s  = (state == ST_START);
    assign is_finish_s = state[1];

    // Positions arrive from a slow domain: synchronize, then accept only a value
    // seen unchanged on two consecutive cycles so mid-update words are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync1_r <= 16'h0000; a_sync2_r <= 16'h0000; a_prev_r <= 16'h0000; a_filt_r <= 16'h0000;
            b_sync1_r <= 16'h0000; b_sync2_r <= 16'h0000; b_prev_r <= 16'h0000; b_filt_r <= 16'h0000;
        end else begin
            a_sync1_r <= pos_a;
            a_sync2_r <= a_sync1_r;
            a_prev_r  <= a_sync2_r;
            b_sync1_r <= pos_b;
            b_sync2_r <= b_sync1_r;
            b_prev_r  <= b_sync2_r;
            if (a_sync2_r == a_prev_r) a_filt_r <= a_sync2_r;
            if (b_sync2_r == b_prev_r) b_filt_r <= b_sync2_r;
        end
    end

    assign contact_s = |(({a_filt_r[14:0], 1'b0} & b_filt_r) |
                         ({1'b0, a_filt_r[15:1]} & b_filt_r) |
                         (a_filt_r & b_filt_r));
    assign con_inc_s = contact_s & ~contact_q_r & is_start_s;

    // Contact history and the one-cycle event pulse, aligned with the count update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contact_q_r <= 1'b0;
            contact_evt <= 1'b0;
        end else if (is_reset_s) begin
            contact_q_r <= 1'b0;
            contact_evt <= 1'b0;
        end else begin
            contact_q_r <= contact_s;
            contact_evt <= con_inc_s;
        end
    end

    assign tick_s = is_start_s && (tick_r == TICK_W'(TICK_CYCLES - 1));

    // One-second prescaler; runs only while playing, holds in FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r <= '0;
        end else if (is_reset_s) begin
            tick_r <= '0;
        end else if (is_start_s) begin
            tick_r <= tick_s ? '0 : tick_r + TICK_W'(1);
        end else begin
            tick_r <= tick_r;
        end
    end

    bcd_sat_counter u_seconds (
        .clk   (clk),
        .rst   (rst),
        .clr   (is_reset_s),
        .inc   (tick_s),
        .count (sec_bcd_s)
    );

    bcd_sat_counter u_contacts (
        .clk   (clk),
        .rst   (rst),
        .clr   (is_reset_s),
        .inc   (con_inc_s),
        .count (con_bcd_s)
    );

    // FINISH blink phase; restarts visible whenever FINISH is (re)entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_r <= '0;
            hide_r  <= 1'b0;
        end else if (!is_finish_s) begin
            blink_r <= '0;
            hide_r  <= 1'b0;
        end else if (blink_r == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_r <= '0;
            hide_r  <= ~hide_r;
        end else begin
            blink_r <= blink_r + BLINK_W'(1);
        end
    end

    assign scan_wrap_s = (scan_cnt_r == SCAN_W'(SCAN_CYCLES - 1));
    assign idx_nxt_s   = scan_on_r ? scan_idx_r + 2'd1 : 2'd0;
    assign on_nxt_s    = scan_on_r | scan_wrap_s;
    assign show_idx_s  = scan_wrap_s ? idx_nxt_s : scan_idx_r;

    // Digit code for the position being driven after this edge.
    always_comb begin
        code_s = DIG_BLANK;
        if (is_reset_s) begin
            code_s = DIG_DASH;
        end else if (is_finish_s && hide_r) begin
            code_s = DIG_BLANK;
        end else begin
            case (show_idx_s)
                2'd3:    code_s = sec_bcd_s[7:4];
                2'd2:    code_s = sec_bcd_s[3:0];
                2'd1:    code_s = con_bcd_s[7:4];
                default: code_s = con_bcd_s[3:0];
            endcase
        end
    end

    // Digit scan; enables and segments share one register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 2'd0;
            scan_on_r  <= 1'b0;
            digit      <= 4'b1111;
            display    <= SEG_BLANK;
        end else begin
            scan_cnt_r <= scan_wrap_s ? '0 : scan_cnt_r + SCAN_W'(1);
            if (scan_wrap_s) begin
                scan_idx_r <= idx_nxt_s;
                scan_on_r  <= 1'b1;
            end
            digit   <= on_nxt_s ? ~(4'b0001 << show_idx_s) : 4'b1111;
            display <= on_nxt_s ? seg_encode(code_s) : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_snake_score_display.sv
// Self-checking bench for snake_score_display: integer-level game model compared
// every cycle, plus directed literal expectations.
module tb_snake_score_display;

    localparam int TC = 10;
    localparam int SC = 4;
    localparam int BC = 20;

    logic        clk;
    logic        rst;
    logic [1:0]  state;
    logic [15:0] pos_a, pos_b;
    logic [3:0]  digit;
    logic [6:0]  display;
    logic        contact_evt;

    int errors = 0;
    int checks = 0;
    int evt_total = 0;
    int evt_base;

    snake_score_display #(.TICK_CYCLES(TC), .SCAN_CYCLES(SC), .BLINK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .state(state), .pos_a(pos_a), .pos_b(pos_b),
        .digit(digit), .display(display), .contact_evt(contact_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int sec_m, con_m, tick_m, blink_m, scan_m, idx_m;
    bit hide_m, on_m, cq_m, evt_m;
    logic [15:0] ha [3];
    logic [15:0] hb [3];
    logic [15:0] fa_m, fb_m;
    logic [3:0]  dig_m;
    logic [6:0]  disp_m;

    function automatic bit touching(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 16; i++)
            for (int j = i - 1; j <= i + 1; j++)
                if (j >= 0 && j < 16 && a[i] && b[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  11: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] shown(input int idx);
        if (state == 2'd0) return seg_of(11);
        if (state >= 2'd2 && hide_m) return seg_of(10);
        case (idx)
            3: return seg_of(sec_m / 10);
            2: return seg_of(sec_m % 10);
            1: return seg_of(con_m / 10);
            default: return seg_of(con_m % 10);
        endcase
    endfunction

    function automatic logic [3:0] enable_of(input int idx);
        return ~(4'b0001 << idx);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_m <= 0; con_m <= 0; tick_m <= 0; blink_m <= 0; scan_m <= 0; idx_m <= 0;
            hide_m <= 1'b0; on_m <= 1'b0; cq_m <= 1'b0; evt_m <= 1'b0;
            for (int k = 0; k < 3; k++) begin ha[k] <= 16'h0; hb[k] <= 16'h0; end
            fa_m <= 16'h0; fb_m <= 16'h0;
            dig_m <= 4'b1111; disp_m <= 7'b1111111;
        end else begin
            ha[0] <= pos_a; ha[1] <= ha[0]; ha[2] <= ha[1];
            hb[0] <= pos_b; hb[1] <= hb[0]; hb[2] <= hb[1];
            if (ha[1] == ha[2]) fa_m <= ha[1];
            if (hb[1] == hb[2]) fb_m <= hb[1];
            if (state == 2'd0) begin
                tick_m <= 0; sec_m <= 0; con_m <= 0; cq_m <= 1'b0; evt_m <= 1'b0;
            end else begin
                cq_m  <= touching(fa_m, fb_m);
                evt_m <= (state == 2'd1) && touching(fa_m, fb_m) && !cq_m;
                if (state == 2'd1 && touching(fa_m, fb_m) && !cq_m && con_m < 99) con_m <= con_m + 1;
                if (state == 2'd1) begin
                    if (tick_m == TC - 1) begin
                        tick_m <= 0;
                        if (sec_m < 99) sec_m <= sec_m + 1;
                    end else begin
                        tick_m <= tick_m + 1;
                    end
                end
            end
            if (state < 2'd2) begin
                blink_m <= 0; hide_m <= 1'b0;
            end else if (blink_m == BC - 1) begin
                blink_m <= 0; hide_m <= !hide_m;
            end else begin
                blink_m <= blink_m + 1;
            end
            if (scan_m == SC - 1) begin
                scan_m <= 0;
                on_m   <= 1'b1;
                idx_m  <= on_m ? (idx_m + 1) % 4 : 0;
                dig_m  <= enable_of(on_m ? (idx_m + 1) % 4 : 0);
                disp_m <= shown(on_m ? (idx_m + 1) % 4 : 0);
            end else begin
                scan_m <= scan_m + 1;
                dig_m  <= on_m ? enable_of(idx_m) : 4'b1111;
                disp_m <= on_m ? shown(idx_m) : 7'b1111111;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("digit", {28'd0, digit}, {28'd0, dig_m});
        check("display", {25'd0, display}, {25'd0, disp_m});
        check("contact_evt", {31'd0, contact_evt}, {31'd0, evt_m});
        if (contact_evt) evt_total++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; state = 2'd0; pos_a = 16'h0000; pos_b = 16'h0000;
        cycles(3);
        #1;
        check("reset_digit", {28'd0, digit}, 32'hF);
        check("reset_display", {25'd0, display}, 32'h7F);
        check("reset_evt", {31'd0, contact_evt}, 32'h0);
        @(negedge clk); rst = 1'b0;
        cycles(4); #1;
        check("first_scan_digit", {28'd0, digit}, 32'hE);
        check("first_scan_dash", {25'd0, display}, {25'd0, 7'b0111111});

        // elapsed time, no contact
        @(negedge clk); state = 2'd1;
        cycles(105); #1;
        check("sec_after_105", sec_m, 10);
        check("con_after_105", con_m, 0);

        // contact through adjacency
        pos_a = 16'hE000; pos_b = 16'h0001;
        cycles(8); #1;
        evt_base = evt_total;
        pos_b = 16'h1000;
        cycles(5); #1;
        check("contact_within_5", evt_total - evt_base, 1);
        check("contacts_01", con_m, 1);
        cycles(10); #1;
        check("hold_no_repeat", evt_total - evt_base, 1);
        pos_b = 16'h0001; cycles(8); #1;
        pos_b = 16'h1000; cycles(8); #1;
        check("contacts_02", con_m, 2);

        // one-cycle glitch is filtered
        pos_b = 16'h0001; cycles(8); #1;
        evt_base = evt_total;
        pos_b = 16'h1000; cycles(1); #1;
        pos_b = 16'h0001; cycles(10); #1;
        check("glitch_filtered", evt_total - evt_base, 0);

        // saturation
        evt_base = evt_total;
        for (int i = 0; i < 100; i++) begin
            pos_b = 16'h1000; cycles(4); #1;
            pos_b = 16'h0001; cycles(4); #1;
        end
        cycles(6); #1;
        check("sat_pulses", evt_total - evt_base, 100);
        check("sat_contacts", con_m, 99);
        cycles(60); #1;
        check("sat_seconds", sec_m, 99);

        // FINISH -> RESET -> START clears, then 3 s and FINISH blink
        state = 2'd2; cycles(5);
        state = 2'd0; cycles(3); #1;
        check("reset_dash_again", {25'd0, display}, {25'd0, 7'b0111111});
        check("reset_clears_sec", sec_m, 0);
        state = 2'd1; cycles(30); #1;
        check("three_seconds", sec_m, 3);
        state = 2'd2;
        cycles(5); #1;
        check("finish_visible", {25'd0, display},
              (digit == 4'b1011) ? {25'd0, 7'b0110000} : {25'd0, 7'b1000000});
        cycles(20); #1;
        check("finish_blank", {25'd0, display}, 32'h7F);
        evt_base = evt_total;
        pos_b = 16'h1000; cycles(8); #1;
        check("finish_no_count", evt_total - evt_base, 0);
        check("finish_frozen", con_m, 0);

        // async reset mid-blink
        #1; rst = 1'b1; #1;
        check("async_digit", {28'd0, digit}, 32'hF);
        check("async_display", {25'd0, display}, 32'h7F);
        check("async_evt", {31'd0, contact_evt}, 32'h0);
        cycles(3);
        rst = 1'b0; state = 2'd0;
        cycles(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_score_display.md
# snake_score_display

Downstream stage of the two-snake LED game: consumes the game state and both snake position vectors, counts snake-to-snake contacts and elapsed play seconds, and drives the 4-digit multiplexed seven-segment display. It sits between the game core (state FSM and snake movers) and the board DIGIT/DISPLAY pins, replacing the bare display driver.

## Interface

- TICK_CYCLES, 100_000_000: clk cycles per elapsed-time second.
- SCAN_CYCLES, 32_768: clk cycles each digit stays enabled.
- BLINK_CYCLES, 25_000_000: half-period of the FINISH blink.
- clk  in  1  100 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- state  in  2  game state: 0 RESET, 1 START, 2 FINISH (3 treated as FINISH).
- pos_a  in  16  snake A one-hot-run LED vector (written in a slow clock domain).
- pos_b  in  16  snake B LED vector (slow clock domain).
- digit  out  4  active-low digit enables; bit 0 is rightmost.
- display  out  7  active-low segments, gfedcba.
- contact_evt  out  1  one-clk pulse per counted contact.

## Operation

- Position capture: each of pos_a, pos_b passes through a 2-flop synchronizer, then a stability filter. Filtered value updates only when the synchronized value equals the previous cycle's value. The filter holds during changes.
- Contact = |((a<<1)&b) | ((a>>1)&b) | (a&b) on filtered values; registered as contact_q.
- Contact count: 2-digit BCD, 00..99, saturating at 99. Increments on rising edge of contact_q while state==START. contact_evt pulses in the same cycle as the increment. It still pulses at saturation.
- Seconds count: 2-digit BCD, saturating at 99. A tick counter runs 0..TICK_CYCLES-1 only in START. Wrap to 0 produces one tick, which increments seconds.
- Mode behaviour:
  - state RESET: tick counter, seconds, contacts and contact_q history are cleared synchronously every cycle. Display shows "----" (dash on all digits).
  - START: digits 3..2 show seconds tens/ones; digits 1..0 show contacts tens/ones. Leading zeros are shown.
  - FINISH: counts frozen, same values shown. All digits blank during alternate BLINK_CYCLES windows, starting visible on FINISH entry.
- Segment table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.

## Timing

- Reset values: digit=4'b1111, display=7'b1111111, contact_evt=0, all counters 0, blink phase visible.
- Pin latency: position change to contact_evt is at most 5 clk: 2 sync, 1 stable compare, 1 filter register, 1 contact_q.
- Scan sequence 1110→1101→1011→0111→1110. The first enable (1110) occurs SCAN_CYCLES cycles after reset release. digit and display are registered together, so there are no glitches.
- Simultaneous tick and contact edge in one cycle: both counts update.
- Simultaneous states:
  - State leaving START in the same cycle as a contact edge: not counted.
  - Entering START: tick counter starts from 0, so the first second elapses exactly TICK_CYCLES cycles after entry.
- FINISH→RESET→START clears everything.
- Async rst mid-game returns all to reset values immediately.
- BCD carry: x9→(x+1)0 in one cycle; 99 holds.

## Structure

- Shared package:
  - game state constants RESET/START/FINISH;
  - digit codes BLANK=10, DASH=11;
  - segment encoding function.
- The game core and the display stage both import this package.
- Sub-module bcd_sat_counter (inputs clr, inc; output 8-bit BCD, saturates at 99), instantiated twice (seconds, contacts).
- Scan/blink/tick counters stay in the top.

## Test plan

Run with TICK_CYCLES=10, SCAN_CYCLES=4, BLINK_CYCLES=20.

- Reset: assert rst, state=0 → digit=1111, display=1111111. After release, the first scan yields all four digits showing 0111111.
- Elapsed time: state=1 for 105 clk with no contact → seconds=10 (display digits 3..2 = "10"), contacts "00".
- Contact: pos_a=16'hE000, pos_b=16'h0001, then pos_b steps to 16'h1000 (adjacent) → exactly one contact_evt within 5 clk, contacts "01". Holding the adjacency gives no further pulses; separating then re-touching → "02".
- Saturation: force 100 contact edges → contacts stays "99". contact_evt pulses 100 times.
- Filter: pos_b glitches for 1 clk to an adjacent value → no contact_evt.
- FINISH: state=2 after 3 s → "0300" visible 20 clk, blank 20 clk, repeating. Contacts in FINISH are not counted. Then rst mid-blink → reset values immediately.
